// File: rtl/isag_pkg.sv
// Shared types and bit-permutation helpers for the inverse sheep-and-goats unit.
// Holds the FSM state encoding, the per-stage chain-break selectors and the
// pure functions used by both the control stages and the data stages.
package isag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_C1   = 3'd1,
        ST_C2   = 3'd2,
        ST_C3   = 3'd3,
        ST_D3   = 3'd4,
        ST_D2   = 3'd5,
        ST_D1   = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    // sel[0] breaks the prefix chain before bit 4, sel[1] before bits 2 and 6.
    localparam logic [1:0] SEL_S1 = 2'b00;
    localparam logic [1:0] SEL_S2 = 2'b01;
    localparam logic [1:0] SEL_S3 = 2'b11;

    // Prefix-xor over the control word (restarted at the group boundaries
    // chosen by sel) and derive the pair-swap flags from the even positions.
    function automatic logic [3:0] derive_t(input logic [7:0] w, input logic [1:0] sel);
        logic       acc;
        logic [3:0] t;
        acc = 1'b0;
        t   = '0;
        for (int k = 0; k < 4; k++) begin
            if ((sel[0] && k == 2) || (sel[1] && (k == 1 || k == 3))) begin
                acc = 1'b0;
            end
            acc  = acc ^ w[2*k];
            t[k] = ~acc;
            acc  = acc ^ w[2*k+1];
        end
        return t;
    endfunction

    // Swap bits 2k and 2k+1 wherever t[k] is set.
    function automatic logic [7:0] pair_swap(input logic [7:0] w, input logic [3:0] t);
        logic [7:0] r;
        r = w;
        for (int k = 0; k < 4; k++) begin
            if (t[k]) begin
                r[2*k]   = w[2*k+1];
                r[2*k+1] = w[2*k];
            end
        end
        return r;
    endfunction

    // Interleave the low and high halves: low half to even bits, high half to odd bits.
    function automatic logic [7:0] shuffle(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r[2*i]   = w[i];
            r[2*i+1] = w[i+4];
        end
        return r;
    endfunction

    // Split even bits to the low half and odd bits to the high half.
    function automatic logic [7:0] unshuffle(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i]   = w[2*i];
            r[i+4] = w[2*i+1];
        end
        return r;
    endfunction

endpackage

// File: rtl/isag_stage.sv
// One inverse butterfly data stage: shuffle the word, then swap the pairs
// flagged by t. Purely combinational; the top time-multiplexes it over the
// three stage flag registers.
module isag_stage
    import isag_pkg::*;
(
    input  logic [7:0] d,
    input  logic [3:0] t,
    output logic [7:0] q
);

    assign q = pair_swap(shuffle(d), t);

endmodule

// File: rtl/isag_seq.sv
// Sequential 8-bit inverse sheep-and-goats (scatter) unit.
// Three control cycles derive the butterfly flags from the mask, then three
// data cycles undo the gather network in reverse stage order.
// Optional build macro ISAG_SEQ_FWD_EN adds a fwd input that instead applies
// the forward gather during the control cycles and skips the data cycles.
module isag_seq
    import isag_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_ctrl,
`ifdef ISAG_SEQ_FWD_EN
    input  logic             fwd,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (WIDTH != 8) begin : g_width_check
        $error("isag_seq: only WIDTH=8 is supported");
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] ctrl_q;
    logic [3:0]       t1_q;
    logic [3:0]       t2_q;
    logic [3:0]       t3_q;
    logic             fwd_q;

    logic [1:0]       c_sel;
    logic [3:0]       t_new;
    logic [3:0]       t_mux;
    logic [7:0]       ctrl_next;
    logic [7:0]       fwd_data;
    logic [7:0]       stage_out;

`ifdef ISAG_SEQ_FWD_EN
    // Direction flag captured together with the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q <= 1'b0;
        end else if (state_q == ST_IDLE && in_valid) begin
            fwd_q <= fwd;
        end
    end
`else
    assign fwd_q = 1'b0;
`endif

    // Pick the chain-break pattern for the active control stage and the flag
    // register feeding the shared data stage.
    always_comb begin
        c_sel = SEL_S1;
        t_mux = t1_q;
        case (state_q)
            ST_C2:   c_sel = SEL_S2;
            ST_C3:   c_sel = SEL_S3;
            ST_D3:   t_mux = t3_q;
            ST_D2:   t_mux = t2_q;
            default: ;
        endcase
    end

    assign t_new     = derive_t(ctrl_q, c_sel);
    assign ctrl_next = unshuffle(pair_swap(ctrl_q, t_new));
    assign fwd_data  = unshuffle(pair_swap(data_q, t_new));

    isag_stage u_stage (
        .d (data_q),
        .t (t_mux),
        .q (stage_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing: three control cycles, then three data cycles
    // (skipped in forward mode), then hold until the result is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_C1;
            ST_C1:   state_d = ST_C2;
            ST_C2:   state_d = ST_C3;
            ST_C3:   state_d = fwd_q ? ST_DONE : ST_D3;
            ST_D3:   state_d = ST_D2;
            ST_D2:   state_d = ST_D1;
            ST_D1:   state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Datapath: latch the request, derive one flag set per control cycle,
    // then run the data word through the shared inverse stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            ctrl_q <= '0;
            t1_q   <= '0;
            t2_q   <= '0;
            t3_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        ctrl_q <= in_ctrl;
                    end
                end
                ST_C1: begin
                    t1_q   <= t_new;
                    ctrl_q <= ctrl_next;
                    if (fwd_q) data_q <= fwd_data;
                end
                ST_C2: begin
                    t2_q   <= t_new;
                    ctrl_q <= ctrl_next;
                    if (fwd_q) data_q <= fwd_data;
                end
                ST_C3: begin
                    t3_q   <= t_new;
                    ctrl_q <= ctrl_next;
                    if (fwd_q) data_q <= fwd_data;
                end
                ST_D3, ST_D2, ST_D1: begin
                    data_q <= stage_out;
                end
                default: ;
            endcase
        end
    end

    assign out_data = data_q;

endmodule

// File: doc/isag_seq.md
Name: isag_seq

Overview:
- Sequential 8-bit inverse sheep-and-goats (ISAG) unit; the scatter counterpart of the team's combinational SAG gather.
- For any x and c: isag_seq(sag(x, c), c) == x.
- Iterative datapath:
  - One control stage per cycle.
  - Then one inverse butterfly stage per cycle, in reverse stage order.
- Valid/ready on both sides; intended for the bit-manipulation unit's multi-cycle slot.

Parameters:
WIDTH, 8, data/control width; only 8 supported, any other value is an elaboration error

Ports:
clk  input  1  clock, single clock domain
rst  input  1  synchronous reset, active-high
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
in_data  input  8  gathered word y (sag output)
in_ctrl  input  8  mask c used for the original sag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  8  scattered word x

Behaviour:
- Reference function:
  - Forward sag packs bits with c=1 at the low end, ascending.
  - Bits with c=0 go to the high end, reversed: lowest-index c=0 bit lands at bit 7.
  - ISAG: the k-th set bit of c (ascending) takes y[k]; the j-th clear bit of c (ascending) takes y[7-j].
- Control stage s (s=1,2,3, sel = 00, 01, 11):
  - Prefix-xor x[i] over the stage control word.
  - Chain broken before bit 4 when sel[0]=1, and before bits 2 and 6 when sel[1]=1.
  - t_s[k] = NOT x[2k].
  - Next control word = swap pair k when t_s[k], then unshuffle (even bits to [3:0], odd bits to [7:4]).
- Inverse data stage with t:
  - Shuffle: out[2i] = in[i], out[2i+1] = in[i+4].
  - Then swap pair k when t[k].
- States:
  - IDLE → C1 → C2 → C3 → D3 → D2 → D1 → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_data/in_ctrl and go to C1.
- C1..C3: compute and register t1, t2, t3 respectively, one per cycle.
- D3, D2, D1: apply the inverse data stage with t3, t2, t1 respectively to the data register.
- DONE:
  - out_valid=1; out_data stable.
  - On out_ready go to IDLE.
- Latency and throughput:
  - out_valid rises exactly 7 cycles after the accepting edge.
  - in_ready=0 in every state except IDLE; one request per ≥8 cycles.
- out_valid is never asserted outside DONE; out_data holds the data register at all times (don't-care when out_valid=0).
- in_valid while busy is ignored; no queuing.
- out_ready held low keeps DONE indefinitely with data stable.
- Reset values: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, out_data=0, t registers 0.
- rst mid-operation aborts the request: next cycle IDLE, out_valid=0, no output produced.
- rst has priority over all handshakes in the same cycle.

Optional Feature:
- Macro: ISAG_SEQ_FWD_EN.
- Defined:
  - Adds input port fwd (1 bit), latched with the request.
  - fwd=1 performs forward sag: each control stage Cs also applies the forward data stage with the freshly computed t_s (swap then unshuffle).
  - Data stages D3..D1 are then skipped: C3 → DONE, so out_valid comes 4 cycles after accept.
  - fwd=0 behaves as the base block.
- Undefined: no fwd port; inverse only.

Decomposition:
- Package isag_pkg:
  - State enum.
  - Stage sel constants (00, 01, 11).
  - Functions: prefix-xor/t derivation, pair-swap, shuffle, unshuffle.
- One sub-module: isag_stage — combinational inverse data stage (shuffle + conditional swap).
  - Reused across D3..D1 through a mux on the t register; C-stage logic stays inline.

Test Plan:
- c=0x0F, y=0x55 → out_data=0xA5; out_valid exactly 7 cycles after accept.
- c=0x00, y=0x01 → 0x80; c=0xFF, y=0x3C → 0x3C (identity).
- c=0x01, y=0x80 → 0x02; c=0x01, y=0x01 → 0x01.
- out_ready low 5 cycles in DONE → out_data stable; in_valid pulses during busy ignored; next request accepted only in IDLE.
- rst asserted in D2 → next cycle IDLE, out_valid=0; a subsequent request with c=0x0F, y=0x55 yields 0xA5.
- Random x, c (≥10k): feed sag(x, c) → out_data == x. With ISAG_SEQ_FWD_EN, fwd=1 on x=0xA5, c=0x0F → 0x55 after 4 cycles.
